// File: rtl/cr_kme_fifo_param.sv
// Parameterised fall-through FIFO with registered occupancy counters, advisory stall and error pulses.
// Optional peak-occupancy tracking is enabled by defining CR_KME_FIFO_HIGH_WATER_EN.
module cr_kme_fifo_param #(
  parameter int DATA_W       = 64,
  parameter int DEPTH        = 16,
  parameter int STALL_THRESH = 0,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] fifo_in,
  input  logic              fifo_in_valid,
  input  logic              fifo_in_stall_override,
  input  logic              fifo_out_ack,
  input  logic              clear,
  output logic              fifo_in_stall,
  output logic [DATA_W-1:0] fifo_out,
  output logic              fifo_out_valid,
  output logic [CW-1:0]     used_slots,
  output logic [CW-1:0]     free_slots,
  output logic              fifo_overflow,
  output logic              fifo_underflow,
  output logic [CW-1:0]     high_water
);

  localparam int AW = CW - 1;
  localparam logic [CW-1:0] DEPTH_CW  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_CW = CW'(STALL_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     rd_ptr;
  logic              empty;
  logic              full;
  logic              rd_en;
  logic              wr_en;
  logic              ovf_ev;
  logic              unf_ev;

  // Handshake: a write happens when fifo_in_valid is high and there is room (or a read frees a slot
  // in the same cycle); a read happens when fifo_out_valid and fifo_out_ack are both high.
  // fifo_in_stall is advisory only and never blocks a write that fits.
  always_comb begin
    empty  = (wr_ptr == rd_ptr);
    full   = (wr_ptr[CW-1] != rd_ptr[CW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_en  = fifo_out_ack && !empty;
    wr_en  = fifo_in_valid && (!full || rd_en);
    ovf_ev = fifo_in_valid && full && !rd_en;
    unf_ev = fifo_out_ack && empty;
  end

  assign fifo_out_valid = !empty;
  assign fifo_out       = mem[rd_ptr[AW-1:0]];
  assign fifo_in_stall  = (free_slots <= THRESH_CW) || fifo_in_stall_override;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem[wr_ptr[AW-1:0]] <= fifo_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      used_slots     <= '0;
      free_slots     <= DEPTH_CW;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else if (clear) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      used_slots     <= '0;
      free_slots     <= DEPTH_CW;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + CW'(1);
      if (rd_en) rd_ptr <= rd_ptr + CW'(1);
      case ({wr_en, rd_en})
        2'b10: begin
          used_slots <= used_slots + CW'(1);
          free_slots <= free_slots - CW'(1);
        end
        2'b01: begin
          used_slots <= used_slots - CW'(1);
          free_slots <= free_slots + CW'(1);
        end
        default: ;
      endcase
      fifo_overflow  <= ovf_ev;
      fifo_underflow <= unf_ev;
    end
  end

`ifdef CR_KME_FIFO_HIGH_WATER_EN
  logic [CW-1:0] high_water_q;

  // Tracks the registered count, so the peak lags used_slots by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water_q <= '0;
    end else if (clear) begin
      high_water_q <= '0;
    end else if (used_slots > high_water_q) begin
      high_water_q <= used_slots;
    end
  end

  assign high_water = high_water_q;
`else
  assign high_water = '0;
`endif

endmodule

// File: tb/tb_cr_kme_fifo_param.sv
// Self-checking bench for cr_kme_fifo_param: table-driven vectors on a DEPTH=16/THRESH=0 instance,
// plus hand-written sequences for threshold, high-water, clear and asynchronous reset.
module tb_cr_kme_fifo_param;

  localparam int W  = 64;
  localparam int CW = 5;
`ifdef CR_KME_FIFO_HIGH_WATER_EN
  localparam logic [W-1:0] HW_PEAK = 64'd9;
`else
  localparam logic [W-1:0] HW_PEAK = 64'd0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT: STALL_THRESH = 0
  logic [W-1:0]  din;
  logic          vld, ovr, ack, clr;
  logic          stall, ovalid, ovf, unf;
  logic [W-1:0]  dout;
  logic [CW-1:0] used, free, hw;

  cr_kme_fifo_param #(.DATA_W(W), .DEPTH(16), .STALL_THRESH(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_in(din), .fifo_in_valid(vld),
    .fifo_in_stall_override(ovr), .fifo_out_ack(ack), .clear(clr),
    .fifo_in_stall(stall), .fifo_out(dout), .fifo_out_valid(ovalid),
    .used_slots(used), .free_slots(free), .fifo_overflow(ovf),
    .fifo_underflow(unf), .high_water(hw)
  );

  // threshold DUT: STALL_THRESH = 3
  logic [W-1:0]  th_din;
  logic          th_vld, th_ovr, th_ack, th_clr;
  logic          th_stall, th_ovalid, th_ovf, th_unf;
  logic [W-1:0]  th_dout;
  logic [CW-1:0] th_used, th_free, th_hw;

  cr_kme_fifo_param #(.DATA_W(W), .DEPTH(16), .STALL_THRESH(3)) u_th (
    .clk(clk), .rst_n(rst_n), .fifo_in(th_din), .fifo_in_valid(th_vld),
    .fifo_in_stall_override(th_ovr), .fifo_out_ack(th_ack), .clear(th_clr),
    .fifo_in_stall(th_stall), .fifo_out(th_dout), .fifo_out_valid(th_ovalid),
    .used_slots(th_used), .free_slots(th_free), .fifo_overflow(th_ovf),
    .fifo_underflow(th_unf), .high_water(th_hw)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         vld;
    logic [W-1:0] din;
    logic         ack;
    logic         clr;
    logic         ovr;
    int           used;
    logic         ovalid;
    logic [W-1:0] dout;
    logic         stall;
    logic         ovf;
    logic         unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [W-1:0] d, logic a, logic c, logic o,
                              int u, logic ov, logic [W-1:0] q, logic s, logic of, logic uf);
    vec_t r;
    r.vld = v; r.din = d; r.ack = a; r.clr = c; r.ovr = o;
    r.used = u; r.ovalid = ov; r.dout = q; r.stall = s; r.ovf = of; r.unf = uf;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] d, input logic a,
                       input logic c, input logic o);
    vld = v; din = d; ack = a; clr = c; ovr = o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    string tag;
    drive(v.vld, v.din, v.ack, v.clr, v.ovr);
    step();
    tag = $sformatf("vec%0d", idx);
    chk({tag, ".used"},  W'(used), W'(v.used));
    chk({tag, ".free"},  W'(free), W'(16 - v.used));
    chk({tag, ".valid"}, W'(ovalid), W'(v.ovalid));
    chk({tag, ".stall"}, W'(stall), W'(v.stall));
    chk({tag, ".ovf"},   W'(ovf), W'(v.ovf));
    chk({tag, ".unf"},   W'(unf), W'(v.unf));
    if (v.ovalid) chk({tag, ".dout"}, dout, v.dout);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, ".used"},  W'(used), 64'd0);
    chk({tag, ".free"},  W'(free), 64'd16);
    chk({tag, ".valid"}, W'(ovalid), 64'd0);
    chk({tag, ".ovf"},   W'(ovf), 64'd0);
    chk({tag, ".unf"},   W'(unf), 64'd0);
    chk({tag, ".hw"},    W'(hw), 64'd0);
    chk({tag, ".stall"}, W'(stall), W'(ovr));
  endtask

  // ---------------- test ----------------
  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    th_vld = 1'b0; th_din = '0; th_ack = 1'b0; th_clr = 1'b0; th_ovr = 1'b0;

    // Vectors: empty-ack underflow, 0xA5 fall-through, fill 0..F, overflow, full read+write,
    // drain, simultaneous read/write, clear priority, override.
    tbl.push_back(mk(0, 64'h0,  1, 0, 0, 0, 0, 64'h0,  0, 0, 1));
    tbl.push_back(mk(1, 64'hA5, 0, 0, 0, 1, 1, 64'hA5, 0, 0, 0));
    tbl.push_back(mk(0, 64'h0,  1, 0, 0, 0, 0, 64'h0,  0, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, W'(i), 0, 0, 0, i + 1, 1, 64'h0, (i == 15), 0, 0));
    tbl.push_back(mk(1, 64'h99, 0, 0, 0, 16, 1, 64'h0, 1, 1, 0));
    tbl.push_back(mk(0, 64'h0,  0, 0, 0, 16, 1, 64'h0, 1, 0, 0));
    tbl.push_back(mk(1, 64'h10, 1, 0, 0, 16, 1, 64'h1, 1, 0, 0));
    for (int j = 1; j < 16; j++)
      tbl.push_back(mk(0, 64'h0, 1, 0, 0, 16 - j, 1, W'(j + 1), 0, 0, 0));
    tbl.push_back(mk(0, 64'h0,  1, 0, 0, 0, 0, 64'h0,  0, 0, 0));
    tbl.push_back(mk(1, 64'h21, 0, 0, 0, 1, 1, 64'h21, 0, 0, 0));
    tbl.push_back(mk(1, 64'h22, 1, 0, 0, 1, 1, 64'h22, 0, 0, 0));
    tbl.push_back(mk(1, 64'h23, 1, 0, 0, 1, 1, 64'h23, 0, 0, 0));
    tbl.push_back(mk(1, 64'h24, 1, 1, 0, 0, 0, 64'h0,  0, 0, 0));
    tbl.push_back(mk(0, 64'h0,  1, 1, 0, 0, 0, 64'h0,  0, 0, 0));
    tbl.push_back(mk(0, 64'h0,  1, 0, 0, 0, 0, 64'h0,  0, 0, 1));
    tbl.push_back(mk(0, 64'h0,  0, 0, 1, 0, 0, 64'h0,  1, 0, 0));

    // Reset state, including stall override while in reset.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("rst");
    th_ovr = 1'b1; #1;
    chk("rst.th_stall_ovr", W'(th_stall), 64'd1);
    th_ovr = 1'b0; #1;
    chk("rst.th_stall", W'(th_stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[k]) apply_vec(tbl[k], k);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Threshold 3: override on empty, fill to 12, then 13.
    th_ovr = 1'b1; #1;
    chk("th.ovr_empty", W'(th_stall), 64'd1);
    th_ovr = 1'b0; #1;
    chk("th.empty", W'(th_stall), 64'd0);
    th_vld = 1'b1;
    for (int i = 0; i < 12; i++) begin
      th_din = W'(i);
      step();
    end
    th_vld = 1'b0; #1;
    chk("th.used12", W'(th_used), 64'd12);
    chk("th.stall12", W'(th_stall), 64'd0);
    th_vld = 1'b1; th_din = 64'hC;
    step();
    th_vld = 1'b0; #1;
    chk("th.used13", W'(th_used), 64'd13);
    chk("th.stall13", W'(th_stall), 64'd1);
    chk("th.head", th_dout, 64'h0);

    // High water: fill to 9, drain to 2.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, W'(64'h100 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    step();
    chk("hw.used2", W'(used), 64'd2);
    chk("hw.head", dout, 64'h107);
    chk("hw.peak", W'(hw), HW_PEAK);

    // Clear with write asserted.
    drive(1'b1, 64'hEE, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("clr.used", W'(used), 64'd0);
    chk("clr.free", W'(free), 64'd16);
    chk("clr.valid", W'(ovalid), 64'd0);
    chk("clr.hw", W'(hw), 64'd0);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'(64'h200 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("burst.used5", W'(used), 64'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_values("midrst");
    drive(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("postrst.used", W'(used), 64'd1);
    chk("postrst.valid", W'(ovalid), 64'd1);
    chk("postrst.dout", dout, 64'h77);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cr_kme_fifo_param.md
CR_KME_FIFO_PARAM -- requirements
Module: cr_kme_fifo_param

Interface
REQ-001 Parameter DATA_W, default 64: data width in bits; legal range 1..512.
REQ-002 Parameter DEPTH, default 16: entry count; power of two, at least 2.
REQ-003 Parameter STALL_THRESH, default 0: stall asserts when free_slots <= STALL_THRESH; legal range 0..DEPTH-1.
REQ-004 Width CW = log2(DEPTH)+1 throughout.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 fifo_in  input  DATA_W  write data.
REQ-008 fifo_in_valid  input  1  write request.
REQ-009 fifo_in_stall_override  input  1  forces fifo_in_stall high.
REQ-010 fifo_out_ack  input  1  consumer accepts head entry.
REQ-011 clear  input  1  synchronous flush.
REQ-012 fifo_in_stall  output  1  backpressure to producer.
REQ-013 fifo_out  output  DATA_W  head entry, fall-through.
REQ-014 fifo_out_valid  output  1  FIFO non-empty.
REQ-015 used_slots, free_slots  output  CW each  occupancy and vacancy.
REQ-016 fifo_overflow, fifo_underflow  output  1 each  one-cycle error pulses.
REQ-017 high_water  output  CW  peak occupancy (see Configuration).

Function
REQ-018 Storage: DEPTH x DATA_W array, write and read pointers CW bits wide, wrapping modulo 2*DEPTH; empty when pointers are equal; full when the MSBs differ and the low bits are equal.
REQ-019 fifo_out_valid = !empty; fifo_out is the head entry, combinational from registered state; zero added latency; a write into an empty FIFO is visible the cycle after the write edge.
REQ-020 Read occurs when fifo_out_valid && fifo_out_ack; the read pointer advances by 1.
REQ-021 Write occurs when fifo_in_valid && (!full || read occurs this cycle); full plus simultaneous read means the write is accepted and occupancy is unchanged.
REQ-022 Write while full with no read: data is dropped, pointers are unchanged, and fifo_overflow pulses high for exactly the next cycle.
REQ-023 fifo_out_ack while empty: no pointer change; fifo_underflow pulses high for the next cycle.
REQ-024 Simultaneous read and write when not full and not empty: both occur; occupancy is unchanged.
REQ-025 used_slots + free_slots = DEPTH at all times; both are registered.
REQ-026 fifo_in_stall = (free_slots <= STALL_THRESH) || fifo_in_stall_override; combinational from registered count and the input.
REQ-027 Stall is advisory; writes during stall are still accepted when not full.
REQ-028 clear has priority over read and write in the same cycle: next cycle used_slots=0; no overflow or underflow pulse is generated for that cycle.
REQ-029 Array contents are not reset; only pointers, counts and flags are.

Reset
REQ-030 While rst_n=0: pointers=0, used_slots=0, free_slots=DEPTH, fifo_out_valid=0, fifo_overflow=0, fifo_underflow=0, high_water=0.
REQ-031 An asynchronous reset mid-operation discards all entries; the first write is accepted on the first rising edge after rst_n deasserts.
REQ-032 fifo_in_stall during reset = (DEPTH <= STALL_THRESH) || fifo_in_stall_override, i.e. the override only for legal parameters.

Configuration
REQ-033 Macro CR_KME_FIFO_HIGH_WATER_EN defined: high_water register holds max(used_slots) since the last reset or clear; it updates one cycle after used_slots; clear resets it to 0.
REQ-034 Macro undefined: high_water is tied to 0, no register is synthesised, and all other behaviour is identical.

Verification
REQ-035 DEPTH=16, THRESH=0: write 16 words 0x0..0xF with no ack -> used_slots=16, free_slots=0, fifo_in_stall=1, fifo_overflow=0.
REQ-036 Full FIFO, fifo_in_valid=1 with ack=0 -> fifo_overflow=1 for one cycle; contents still 0x0..0xF; subsequent reads return 0x0..0xF in order.
REQ-037 Full FIFO, fifo_in_valid=1 and ack=1 in the same cycle -> 0x0 read, new word accepted, used_slots stays 16, no overflow.
REQ-038 Empty FIFO, ack=1 -> fifo_underflow=1 for one cycle, used_slots=0; then write 0xA5 -> fifo_out=0xA5 and valid=1 on the next cycle.
REQ-039 THRESH=3: fill to 12 -> stall=0; fill to 13 -> stall=1; override=1 on an empty FIFO -> stall=1.
REQ-040 Macro on: fill to 9, drain to 2 -> high_water=9; clear with write asserted -> used_slots=0, high_water=0; rst_n pulsed mid-burst -> all REQ-030 values.
